// File: rtl/xbar_xfer_controller.sv
// Per-output packet transfer controller between the round-robin switch arbiter and the
// crossbar datapath. Each output accepts one granted input, stays locked to it for the
// whole packet and pops flits under per-output credit flow control.
module xbar_xfer_controller #(
  parameter int unsigned NUM_PORTS   = 8,
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned MAX_CREDITS = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_PORTS-1:0]         grant_valid,
  input  logic [3*NUM_PORTS-1:0]       grant_out,
  input  logic [LEN_W*NUM_PORTS-1:0]   pkt_len,
  input  logic [NUM_PORTS-1:0]         credit_return,
  output logic [NUM_PORTS-1:0]         ack,
  output logic [3*NUM_PORTS-1:0]       xbar_sel,
  output logic [NUM_PORTS-1:0]         xbar_sel_valid,
  output logic [NUM_PORTS-1:0]         flit_pop,
  output logic [NUM_PORTS-1:0]         input_locked,
  output logic                         credit_err
);

  localparam logic [2:0] MaxCred = 3'(MAX_CREDITS);

  typedef enum logic {StIdle, StXfer} state_e;

  state_e           state_q   [NUM_PORTS];
  state_e           state_d   [NUM_PORTS];
  logic [2:0]       src_q     [NUM_PORTS];
  logic [2:0]       src_d     [NUM_PORTS];
  logic [LEN_W-1:0] remain_q  [NUM_PORTS];
  logic [LEN_W-1:0] remain_d  [NUM_PORTS];
  logic [2:0]       credits_q [NUM_PORTS];
  logic [2:0]       credits_d [NUM_PORTS];
  logic             credit_err_q, credit_err_d;

  logic [NUM_PORTS-1:0] has_cand;
  logic [2:0]           win [NUM_PORTS];
  logic [NUM_PORTS-1:0] pop_o;

  // Ownership and select outputs come straight from per-output state flops.
  always_comb begin
    input_locked   = '0;
    xbar_sel_valid = '0;
    xbar_sel       = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      xbar_sel[3*o +: 3] = src_q[o];
      if (state_q[o] == StXfer) begin
        xbar_sel_valid[o]       = 1'b1;
        input_locked[src_q[o]]  = 1'b1;
      end
    end
  end

  // Candidate search per output; descending scan so the lowest input index wins.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      has_cand[o] = 1'b0;
      win[o]      = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (grant_valid[i] && (grant_out[3*i +: 3] == 3'(o)) && (i != o) &&
            !input_locked[i] && (pkt_len[LEN_W*i +: LEN_W] != '0)) begin
          has_cand[o] = 1'b1;
          win[o]      = 3'(i);
        end
      end
    end
  end

  // Combinational ack and flit pops; both forced low while reset is asserted.
  always_comb begin
    ack      = '0;
    flit_pop = '0;
    pop_o    = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      pop_o[o] = (state_q[o] == StXfer) && (credits_q[o] != '0);
      ack[o]   = reset_n && (state_q[o] == StIdle) && (credits_q[o] != '0) && has_cand[o];
      if (pop_o[o] && reset_n) begin
        flit_pop[src_q[o]] = 1'b1;
      end
    end
  end

  // Next-state: packet FSM, length countdown and credit accounting per output.
  always_comb begin
    credit_err_d = credit_err_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_d[o]   = state_q[o];
      src_d[o]     = src_q[o];
      remain_d[o]  = remain_q[o];
      credits_d[o] = credits_q[o];
      unique case (state_q[o])
        StIdle: begin
          if (ack[o]) begin
            state_d[o]  = StXfer;
            src_d[o]    = win[o];
            remain_d[o] = pkt_len[LEN_W*int'(win[o]) +: LEN_W];
          end
        end
        StXfer: begin
          if (pop_o[o]) begin
            remain_d[o] = remain_q[o] - LEN_W'(1);
            if (remain_q[o] == LEN_W'(1)) begin
              state_d[o] = StIdle;
            end
          end
        end
        default: state_d[o] = StIdle;
      endcase
      if (credit_return[o] && !pop_o[o]) begin
        if (credits_q[o] == MaxCred) begin
          credit_err_d = 1'b1;
        end else begin
          credits_d[o] = credits_q[o] + 3'd1;
        end
      end else if (!credit_return[o] && pop_o[o]) begin
        credits_d[o] = credits_q[o] - 3'd1;
      end
    end
  end

  // State registers; reset abandons any packet in flight without draining.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o]   <= StIdle;
        src_q[o]     <= '0;
        remain_q[o]  <= '0;
        credits_q[o] <= MaxCred;
      end
      credit_err_q <= 1'b0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o]   <= state_d[o];
        src_q[o]     <= src_d[o];
        remain_q[o]  <= remain_d[o];
        credits_q[o] <= credits_d[o];
      end
      credit_err_q <= credit_err_d;
    end
  end

  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_xbar_xfer_controller.sv
// Directed bench for xbar_xfer_controller: a table of combinational ack vectors taken
// with every output idle, plus hand-written multi-cycle sequences.
module tb_xbar_xfer_controller;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  grant_valid;
  logic [23:0] grant_out;
  logic [31:0] pkt_len;
  logic [7:0]  credit_return;
  logic [7:0]  ack;
  logic [23:0] xbar_sel;
  logic [7:0]  xbar_sel_valid;
  logic [7:0]  flit_pop;
  logic [7:0]  input_locked;
  logic        credit_err;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  xbar_xfer_controller #(
    .NUM_PORTS   (8),
    .LEN_W       (4),
    .MAX_CREDITS (4)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .grant_valid    (grant_valid),
    .grant_out      (grant_out),
    .pkt_len        (pkt_len),
    .credit_return  (credit_return),
    .ack            (ack),
    .xbar_sel       (xbar_sel),
    .xbar_sel_valid (xbar_sel_valid),
    .flit_pop       (flit_pop),
    .input_locked   (input_locked),
    .credit_err     (credit_err)
  );

  typedef struct packed {
    logic [7:0]      gv;
    logic [7:0][2:0] go;
    logic [7:0][3:0] pl;
    logic [7:0]      exp_ack;
  } vec_t;

  function automatic vec_t add_g(vec_t v, int i, int o, int l);
    v.gv[i] = 1'b1;
    v.go[i] = 3'(o);
    v.pl[i] = 4'(l);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic clear_in();
    grant_valid   = '0;
    grant_out     = '0;
    pkt_len       = '0;
    credit_return = '0;
  endtask

  task automatic set_g(input int i, input int o, input int l);
    grant_valid[i]       = 1'b1;
    grant_out[3*i +: 3]  = 3'(o);
    pkt_len[4*i +: 4]    = 4'(l);
  endtask

  // Step to 1ns after the next rising edge; inputs are driven here, checks 1ns later.
  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_in();
    repeat (2) @(posedge clock);
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  vec_t vecs[8];
  vec_t v;

  initial begin
    v = '0; v = add_g(v, 2, 5, 3);                                v.exp_ack = 8'h20; vecs[0] = v;
    v = '0; v = add_g(v, 1, 0, 2); v = add_g(v, 3, 0, 2);         v.exp_ack = 8'h01; vecs[1] = v;
    v = '0; v = add_g(v, 4, 4, 5);                                v.exp_ack = 8'h00; vecs[2] = v;
    v = '0; v = add_g(v, 0, 1, 0);                                v.exp_ack = 8'h00; vecs[3] = v;
    v = '0; v = add_g(v, 0, 3, 1); v = add_g(v, 7, 6, 15); v = add_g(v, 5, 5, 2);
    v.exp_ack = 8'h48; vecs[4] = v;
    v = '0; v = add_g(v, 0, 1, 1); v.gv = '0;                     v.exp_ack = 8'h00; vecs[5] = v;
    v = '0;
    for (int i = 0; i < 8; i++) v = add_g(v, i, (i + 1) % 8, 1);
    v.exp_ack = 8'hFF; vecs[6] = v;
    v = '0; v = add_g(v, 4, 6, 0); v = add_g(v, 5, 6, 15); v = add_g(v, 6, 2, 1);
    v = add_g(v, 2, 6, 4);
    v.exp_ack = 8'h44; vecs[7] = v;

    do_reset();
    #1;
    chk("reset ack", 32'(ack), 32'h0);
    chk("reset xbar_sel", 32'(xbar_sel), 32'h0);
    chk("reset sel_valid", 32'(xbar_sel_valid), 32'h0);
    chk("reset flit_pop", 32'(flit_pop), 32'h0);
    chk("reset locked", 32'(input_locked), 32'h0);
    chk("reset credit_err", 32'(credit_err), 32'h0);

    // Combinational ack table; grants withdrawn before the next edge.
    for (int k = 0; k < 8; k++) begin
      next();
      grant_valid = vecs[k].gv;
      grant_out   = vecs[k].go;
      pkt_len     = vecs[k].pl;
      #1;
      chk($sformatf("table%0d ack", k), 32'(ack), 32'(vecs[k].exp_ack));
      chk($sformatf("table%0d pop", k), 32'(flit_pop), 32'h0);
      clear_in();
    end

    // Single transfer: input 2 -> output 5, 3 flits.
    do_reset();
    next(); set_g(2, 5, 3); #1;
    chk("single ack", 32'(ack), 32'h20);
    for (int k = 1; k <= 3; k++) begin
      next(); clear_in(); #1;
      chk($sformatf("single valid T+%0d", k), 32'(xbar_sel_valid), 32'h20);
      chk($sformatf("single sel T+%0d", k), 32'(xbar_sel[15 +: 3]), 32'd2);
      chk($sformatf("single pop T+%0d", k), 32'(flit_pop), 32'h04);
      chk($sformatf("single locked T+%0d", k), 32'(input_locked), 32'h04);
    end
    next(); #1;
    chk("single idle valid", 32'(xbar_sel_valid), 32'h0);
    chk("single idle pop", 32'(flit_pop), 32'h0);
    chk("single idle locked", 32'(input_locked), 32'h0);
    // One credit left: a 2-flit packet pops once then stalls.
    set_g(2, 5, 2); #1;
    chk("one-credit ack", 32'(ack), 32'h20);
    next(); clear_in(); #1;
    chk("one-credit pop", 32'(flit_pop), 32'h04);
    next(); #1;
    chk("one-credit stall pop", 32'(flit_pop), 32'h0);
    chk("one-credit stall valid", 32'(xbar_sel_valid), 32'h20);

    // Credit stall: input 1 -> output 4, 6 flits, 4 credits.
    do_reset();
    next(); set_g(1, 4, 6); #1;
    chk("stall ack", 32'(ack), 32'h10);
    for (int k = 1; k <= 4; k++) begin
      next(); clear_in(); #1;
      chk($sformatf("stall pop T+%0d", k), 32'(flit_pop), 32'h02);
    end
    next(); #1;
    chk("stall T+5 pop", 32'(flit_pop), 32'h0);
    chk("stall T+5 valid", 32'(xbar_sel_valid), 32'h10);
    next(); credit_return[4] = 1'b1; #1;
    chk("stall T+6 pop", 32'(flit_pop), 32'h0);
    next(); credit_return = '0; #1;
    chk("stall T+7 pop", 32'(flit_pop), 32'h02);
    next(); credit_return[4] = 1'b1; #1;
    chk("stall T+8 pop", 32'(flit_pop), 32'h0);
    next(); #1;
    chk("stall T+9 pop+return", 32'(flit_pop), 32'h02);
    next(); credit_return = '0; #1;
    chk("stall T+10 idle", 32'(xbar_sel_valid), 32'h0);
    // Credits are 1 here; simultaneous pop/return must have left them there.
    set_g(1, 4, 2); #1;
    chk("post-stall ack", 32'(ack), 32'h10);
    next(); clear_in(); #1;
    chk("post-stall pop", 32'(flit_pop), 32'h02);
    next(); #1;
    chk("post-stall stall", 32'(flit_pop), 32'h0);

    // Contention: inputs 1 and 3 both to output 0.
    do_reset();
    next(); set_g(1, 0, 2); set_g(3, 0, 2); #1;
    chk("contend ack", 32'(ack), 32'h01);
    next(); clear_in(); #1;
    chk("contend sel", 32'(xbar_sel[0 +: 3]), 32'd1);
    chk("contend pop", 32'(flit_pop), 32'h02);
    chk("contend locked", 32'(input_locked), 32'h02);

    // Locked input: input 6 -> output 2, then input 6 asks for output 3.
    do_reset();
    next(); set_g(6, 2, 3); #1;
    chk("lock ack2", 32'(ack), 32'h04);
    for (int k = 1; k <= 3; k++) begin
      next(); clear_in(); set_g(6, 3, 2); #1;
      chk($sformatf("lock no-ack T+%0d", k), 32'(ack), 32'h0);
      chk($sformatf("lock pop T+%0d", k), 32'(flit_pop), 32'h40);
    end
    next(); #1;
    chk("lock released ack3", 32'(ack), 32'h08);
    next(); clear_in(); #1;
    chk("lock sel3", 32'(xbar_sel[9 +: 3]), 32'd6);
    chk("lock valid", 32'(xbar_sel_valid), 32'h08);

    // Reset mid-packet with remain=5 and one credit left.
    do_reset();
    next(); set_g(0, 1, 8); #1;
    chk("midrst ack", 32'(ack), 32'h02);
    next(); clear_in();
    next(); next(); next(); #1;
    chk("midrst pre pop", 32'(flit_pop), 32'h01);
    reset_n = 1'b0; #1;
    chk("midrst valid", 32'(xbar_sel_valid), 32'h0);
    chk("midrst pop", 32'(flit_pop), 32'h0);
    chk("midrst locked", 32'(input_locked), 32'h0);
    set_g(3, 2, 1); #1;
    chk("midrst ack gated", 32'(ack), 32'h0);
    clear_in();
    @(posedge clock); #3;
    reset_n = 1'b1;
    next(); set_g(0, 1, 5); #1;
    chk("midrst reack", 32'(ack), 32'h02);
    for (int k = 1; k <= 4; k++) begin
      next(); clear_in(); #1;
      chk($sformatf("midrst reload pop T+%0d", k), 32'(flit_pop), 32'h01);
    end
    next(); #1;
    chk("midrst reload stall", 32'(flit_pop), 32'h0);

    // Credit overflow on output 7.
    do_reset();
    next(); credit_return[7] = 1'b1; #1;
    chk("ovf err before edge", 32'(credit_err), 32'h0);
    next(); credit_return = '0; #1;
    chk("ovf err set", 32'(credit_err), 32'h1);
    next(); #1;
    chk("ovf err sticky", 32'(credit_err), 32'h1);
    set_g(0, 7, 6); #1;
    chk("ovf ack", 32'(ack), 32'h80);
    for (int k = 1; k <= 4; k++) begin
      next(); clear_in(); #1;
      chk($sformatf("ovf pop T+%0d", k), 32'(flit_pop), 32'h01);
    end
    next(); #1;
    chk("ovf saturated stall", 32'(flit_pop), 32'h0);
    chk("ovf err still set", 32'(credit_err), 32'h1);
    do_reset(); #1;
    chk("ovf err cleared by reset", 32'(credit_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
